// File: rtl/bfly_r2_pipe.sv
// Three-stage pipelined radix-2 DIT complex butterfly: x0 = x + w*y, x1 = x - w*y.
// Define BFLY_SAT_EN to clamp out-of-range results; otherwise results wrap to DW bits.
module bfly_r2_pipe #(
   parameter int unsigned DW = 9,
   parameter int unsigned TW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          inv,
   input  logic          scale,
   input  logic [DW-1:0] xr,
   input  logic [DW-1:0] xi,
   input  logic [DW-1:0] yr,
   input  logic [DW-1:0] yi,
   input  logic [TW-1:0] wr,
   input  logic [TW-1:0] wi,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] x0r,
   output logic [DW-1:0] x0i,
   output logic [DW-1:0] x1r,
   output logic [DW-1:0] x1i,
   output logic          ovf,
   input  logic          clr_ovf
);

   localparam int unsigned PW = DW + TW;
   localparam int unsigned SW = PW + 1;
   localparam int unsigned RW = DW + 2;
   localparam logic signed [SW-1:0] RND = SW'(1) << (TW - 2);

   function automatic logic signed [RW-1:0] scl(input logic signed [RW-1:0] v, input logic s);
      return s ? (v >>> 1) : v;
   endfunction

   // Out of DW range when the bits above the DW sign bit disagree with it.
   function automatic logic oor(input logic signed [RW-1:0] v);
      return !((&v[RW-1:DW-1]) || !(|v[RW-1:DW-1]));
   endfunction

   function automatic logic [DW-1:0] reduce(input logic signed [RW-1:0] v);
`ifdef BFLY_SAT_EN
      if (oor(v)) return v[RW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      return v[DW-1:0];
`else
      return v[DW-1:0];
`endif
   endfunction

   logic                 en_c;
   logic                 v1_q, v2_q, v3_q;
   logic signed [DW-1:0] xr1_q, xi1_q, yr1_q, yi1_q;
   logic signed [TW-1:0] wr1_q;
   logic signed [TW:0]   wi1_q;
   logic                 sc1_q;
   logic signed [TW:0]   wi_ext, wi_d;
   logic signed [PW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
   logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
   logic signed [DW-1:0] xr2_q, xi2_q;
   logic                 sc2_q;
   logic signed [SW-1:0] tr_full, ti_full;
   logic signed [RW-1:0] tr, ti, s0r, s0i, s1r, s1i;
   logic                 ovf_set_c;
   logic [DW-1:0]        x0r_q, x0i_q, x1r_q, x1i_q;
   logic                 ovf_q;

   assign en_c     = !v3_q || out_ready;
   assign in_ready = en_c;

   // Conjugate in TW+1 bits so negating -2^(TW-1) stays exact.
   assign wi_ext = (TW+1)'(signed'(wi));
   assign wi_d   = inv ? -wi_ext : wi_ext;

   assign p_rr_d = PW'(wr1_q) * PW'(yr1_q);
   assign p_ii_d = PW'(wi1_q) * PW'(yi1_q);
   assign p_ri_d = PW'(wr1_q) * PW'(yi1_q);
   assign p_ir_d = PW'(wi1_q) * PW'(yr1_q);

   // Round half up, then drop the TW-1 fractional twiddle bits.
   assign tr_full = SW'(p_rr_q) - SW'(p_ii_q) + RND;
   assign ti_full = SW'(p_ri_q) + SW'(p_ir_q) + RND;
   assign tr      = RW'(tr_full >>> (TW - 1));
   assign ti      = RW'(ti_full >>> (TW - 1));

   assign s0r = scl(RW'(xr2_q) + tr, sc2_q);
   assign s0i = scl(RW'(xi2_q) + ti, sc2_q);
   assign s1r = scl(RW'(xr2_q) - tr, sc2_q);
   assign s1i = scl(RW'(xi2_q) - ti, sc2_q);

   assign ovf_set_c = en_c && v2_q && (oor(s0r) || oor(s0i) || oor(s1r) || oor(s1i));

   // Pipeline registers: every stage advances together on en_c, bubbles included.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         xr1_q  <= '0;
         xi1_q  <= '0;
         yr1_q  <= '0;
         yi1_q  <= '0;
         wr1_q  <= '0;
         wi1_q  <= '0;
         sc1_q  <= 1'b0;
         p_rr_q <= '0;
         p_ii_q <= '0;
         p_ri_q <= '0;
         p_ir_q <= '0;
         xr2_q  <= '0;
         xi2_q  <= '0;
         sc2_q  <= 1'b0;
         x0r_q  <= '0;
         x0i_q  <= '0;
         x1r_q  <= '0;
         x1i_q  <= '0;
      end else if (en_c) begin
         v1_q   <= in_valid;
         xr1_q  <= xr;
         xi1_q  <= xi;
         yr1_q  <= yr;
         yi1_q  <= yi;
         wr1_q  <= wr;
         wi1_q  <= wi_d;
         sc1_q  <= scale;
         v2_q   <= v1_q;
         p_rr_q <= p_rr_d;
         p_ii_q <= p_ii_d;
         p_ri_q <= p_ri_d;
         p_ir_q <= p_ir_d;
         xr2_q  <= xr1_q;
         xi2_q  <= xi1_q;
         sc2_q  <= sc1_q;
         v3_q   <= v2_q;
         x0r_q  <= reduce(s0r);
         x0i_q  <= reduce(s0i);
         x1r_q  <= reduce(s1r);
         x1i_q  <= reduce(s1i);
      end
   end

   // Sticky overflow; a new overflow wins over a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_set_c || (ovf_q && !clr_ovf);
   end

   assign out_valid = v3_q;
   assign x0r       = x0r_q;
   assign x0i       = x0i_q;
   assign x1r       = x1r_q;
   assign x1i       = x1i_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_bfly_r2_pipe.sv
// Self-checking bench for bfly_r2_pipe: directed scenarios plus random traffic
// compared against an integer-arithmetic butterfly model with a FIFO scoreboard.
module tb_bfly_r2_pipe;

   localparam int DW = 9;
   localparam int TW = 9;
   localparam int HI = (1 << (DW - 1)) - 1;
   localparam int LO = -(1 << (DW - 1));

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, inv, scale, out_valid, out_ready, ovf, clr_ovf;
   logic [DW-1:0] xr, xi, yr, yi, x0r, x0i, x1r, x1i;
   logic [TW-1:0] wr, wi;

   bfly_r2_pipe #(.DW(DW), .TW(TW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .inv(inv), .scale(scale), .xr(xr), .xi(xi), .yr(yr), .yi(yi),
      .wr(wr), .wi(wi), .out_valid(out_valid), .out_ready(out_ready),
      .x0r(x0r), .x0i(x0i), .x1r(x1r), .x1i(x1i), .ovf(ovf), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   int              n_tests = 0;
   int              n_fail  = 0;
   int              n_cycles = 0;
   logic [4*DW:0]   cur_exp;
   logic [4*DW:0]   q[$];
   bit              sticky = 1'b0;
   bit              front_seen = 1'b0;

   function automatic logic [DW-1:0] d(input int v);
      return DW'(v);
   endfunction

   // Butterfly evaluated in plain integers; MSB of the result is the overflow flag.
   function automatic logic [4*DW:0] model(input int axr, axi, ayr, ayi, awr, awi,
                                           input bit ainv, asc);
      int wie, tr, ti;
      int s[4];
      logic ov;
      logic [4*DW-1:0] r;
      wie = ainv ? -awi : awi;
      tr = (awr * ayr - wie * ayi + (1 << (TW - 2))) >>> (TW - 1);
      ti = (awr * ayi + wie * ayr + (1 << (TW - 2))) >>> (TW - 1);
      s[0] = axr + tr; s[1] = axi + ti; s[2] = axr - tr; s[3] = axi - ti;
      ov = 1'b0;
      r  = '0;
      for (int k = 0; k < 4; k++) begin
         if (asc) s[k] = s[k] >>> 1;
         if (s[k] > HI || s[k] < LO) begin
            ov = 1'b1;
`ifdef BFLY_SAT_EN
            s[k] = (s[k] > HI) ? HI : LO;
`endif
         end
         r[(3-k)*DW +: DW] = DW'(s[k]);
      end
      return {ov, r};
   endfunction

   function automatic int rs(input int n);
      return int'($urandom_range((1 << n) - 1)) - (1 << (n - 1));
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int axr, axi, ayr, ayi, awr, awi, input bit ainv, asc);
      xr = DW'(axr); xi = DW'(axi); yr = DW'(ayr); yi = DW'(ayi);
      wr = TW'(awr); wi = TW'(awi); inv = ainv; scale = asc;
      cur_exp = model(axr, axi, ayr, ayi, awr, awi, ainv, asc);
   endtask

   task automatic drive_rand();
      drive(rs(DW), rs(DW), rs(DW), rs(DW), rs(TW), rs(TW), 1'($urandom), 1'($urandom));
   endtask

   task automatic check_out();
      if (q.size() == 0) chk("no_extra_out", 64'(out_valid), 64'd0);
      else if (out_valid === 1'b1) begin
         chk("result", 64'({x0r, x0i, x1r, x1i}), 64'(q[0][4*DW-1:0]));
         if (!front_seen) begin
            sticky     = sticky | q[0][4*DW];
            front_seen = 1'b1;
         end
      end
      chk("ovf_track", 64'(ovf), 64'(sticky));
   endtask

   // One clock: called just after a falling edge with inputs already driven.
   task automatic tick(output bit accepted);
      bit pop, clr;
      #1;
      accepted = in_valid && in_ready;
      pop      = out_valid && out_ready;
      clr      = clr_ovf;
      @(posedge clk);
      if (pop) begin
         q.delete(0);
         front_seen = 1'b0;
      end
      if (accepted) q.push_back(cur_exp);
      if (clr) sticky = 1'b0;
      #1;
      n_cycles++;
      if (n_cycles > 20000) begin
         $display("FAIL timeout: observed %0d cycles, limit 20000", n_cycles);
         $fatal(1);
      end
      check_out();
      @(negedge clk);
   endtask

   task automatic step();
      bit a;
      tick(a);
   endtask

   initial begin
      bit acc;
      int cyc, sent;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      @(negedge clk); @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_outputs", 64'({x0r, x0i, x1r, x1i}), 64'd0);
      rst = 1'b0;

      // Basic butterfly and 3-cycle latency.
      drive(100, 0, 64, 0, 255, 0, 1'b0, 1'b0);
      in_valid = 1'b1;
      tick(acc);
      chk("t1_accepted", 64'(acc), 64'd1);
      in_valid = 1'b0;
      chk("t1_lat1", 64'(out_valid), 64'd0);
      step();
      chk("t1_lat2", 64'(out_valid), 64'd0);
      step();
      chk("t1_lat3", 64'(out_valid), 64'd1);
      chk("t1_x0", 64'({x0r, x0i}), 64'({d(164), d(0)}));
      chk("t1_x1", 64'({x1r, x1i}), 64'({d(36), d(0)}));
      chk("t1_ovf", 64'(ovf), 64'd0);
      step();

      // Overflow, then the same operands scaled, then clear.
      drive(200, 0, 200, 0, 255, 0, 1'b0, 1'b0);
      in_valid = 1'b1; step(); in_valid = 1'b0; step(); step();
`ifdef BFLY_SAT_EN
      chk("t2_x0r", 64'(x0r), 64'(d(255)));
`else
      chk("t2_x0r", 64'(x0r), 64'(d(-113)));
`endif
      chk("t2_x1r", 64'(x1r), 64'(d(1)));
      chk("t2_ovf", 64'(ovf), 64'd1);
      drive(200, 0, 200, 0, 255, 0, 1'b0, 1'b1);
      in_valid = 1'b1; step(); in_valid = 1'b0; step(); step();
      chk("t2s_x0r", 64'(x0r), 64'(d(199)));
      chk("t2s_x1r", 64'(x1r), 64'(d(0)));
      chk("t2s_ovf", 64'(ovf), 64'd1);
      clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
      chk("t2_clr", 64'(ovf), 64'd0);

      // Conjugate twiddle, back-to-back.
      drive(0, 0, 0, 100, 0, -256, 1'b0, 1'b0);
      in_valid = 1'b1; step();
      drive(0, 0, 0, 100, 0, -256, 1'b1, 1'b0);
      step(); in_valid = 1'b0; step();
      chk("t3_fwd", 64'({x0r, x0i, x1r, x1i}), 64'({d(100), d(0), d(-100), d(0)}));
      step();
      chk("t3_inv", 64'({x0r, x0i, x1r, x1i}), 64'({d(-100), d(0), d(100), d(0)}));
      step(); step();

      // 8-sample stream with a 4-cycle downstream stall.
      sent = 0; cyc = 0;
      drive_rand(); in_valid = 1'b1;
      while (sent < 8 && cyc < 50) begin
         out_ready = !(cyc >= 4 && cyc < 8);
         #1;
         if (cyc >= 4 && cyc < 8) chk("stall_in_ready", 64'(in_ready), 64'd0);
         tick(acc);
         if (acc) begin
            sent++;
            if (sent < 8) drive_rand();
         end
         cyc++;
      end
      chk("stream_sent", 64'(sent), 64'd8);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) step();
      chk("stream_drained", 64'(q.size()), 64'd0);

      // Reset with samples in flight.
      drive(200, 0, 200, 0, 255, 0, 1'b0, 1'b0);
      in_valid = 1'b1; step();
      drive_rand(); step();
      drive_rand(); step();
      in_valid = 1'b0;
      chk("pre_rst_ovf", 64'(ovf), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_ovf", 64'(ovf), 64'd0);
      chk("mid_rst_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_outputs", 64'({x0r, x0i, x1r, x1i}), 64'd0);
      q.delete(); sticky = 1'b0; front_seen = 1'b0;
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_rst_quiet", 64'(out_valid), 64'd0);
      end
      drive(-50, 30, 17, -90, 181, -181, 1'b1, 1'b0);
      in_valid = 1'b1; step(); in_valid = 1'b0;
      step();
      chk("post_rst_lat2", 64'(out_valid), 64'd0);
      step();
      chk("post_rst_lat3", 64'(out_valid), 64'd1);
      step();

      // Random traffic with random back-pressure.
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(9) < 7);
         clr_ovf   = 1'b0;
         drive_rand();
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) step();
      chk("rand_drained", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bfly_r2_pipe.md
# bfly_r2_pipe

Pipelined, parametrised radix-2 decimation-in-time complex butterfly for the audio FFT datapath. It computes x0 = x + w·y and x1 = x − w·y on signed fixed-point complex samples, with:
- configurable data and twiddle widths;
- per-sample conjugate-twiddle (IFFT) mode;
- per-sample divide-by-2 stage scaling;
- round-half-up twiddle products;
- a sticky overflow flag;
- valid/ready flow control.

It replaces the fixed 9-bit combinational butterflies in the FFT stage chain.

## Interface
Parameters:
- DW, 9: data width, signed two's complement, all of xr/xi/yr/yi/x0*/x1*.
- TW, 9: twiddle width, signed Q1.(TW−1); −1.0 representable, +1.0 not (use 2^(TW−1)−1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample presented.
- in_ready  out  1  block accepts input this cycle.
- inv  in  1  1 = use conj(w) (IFFT); sampled with the input.
- scale  in  1  1 = divide both outputs by 2; sampled with the input.
- xr, xi, yr, yi  in  DW  input operands.
- wr, wi  in  TW  twiddle.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- x0r, x0i, x1r, x1i  out  DW  results.
- ovf  out  1  sticky: some result exceeded DW range.
- clr_ovf  in  1  synchronous clear of ovf.

## Operation
- Three register stages:
  - S1 captures operands, inv and scale.
  - S2 registers the four full-precision products wr·yr, wi·yi, wr·yi, wi·yr, each DW+TW bits.
  - S3 registers the final results.
- Conjugation: when inv=1, S1 stores −wi in TW+1 bits, so that −(−2^(TW−1)) is exact.
- Twiddle product, computed in S2→S3 at full precision (DW+TW+1 bits):
  - tr = wr·yr − wi·yi
  - ti = wr·yi + wi·yr
  - Round: add 2^(TW−2), then arithmetic-shift right by TW−1.
- Sum/difference in DW+2 bits: x0 = x + t, x1 = x − t.
- Scaling: if scale=1, arithmetic-shift right by 1 (floor).
- Range reduction to DW: see Configuration. Out of range means the value is outside [−2^(DW−1), 2^(DW−1)−1] before reduction.
- ovf is set in the cycle any of the four results leaves S3 out of range, and holds until clr_ovf or rst.
  - Simultaneous clr_ovf and a new overflow: ovf = 1 (set wins).
- Flow control uses a global pipeline enable: en = !out_valid || out_ready.
  - in_ready = en.
  - A transfer occurs when in_valid && in_ready.
  - On en, all stages shift and valid bits propagate S1→S2→S3.
  - On !en, all stages hold.
  - Bubbles are not collapsed.
- Data registers of invalid stages may hold stale values. Outputs are meaningful only when out_valid=1.

## Timing
- Latency is 3 clk edges from accepted input to out_valid, with no stall.
- Throughput is 1 sample/cycle while out_ready=1.
- While out_valid && !out_ready: outputs are stable, in_ready=0, no input is accepted, and nothing is lost.
- in_ready is combinational from out_ready and out_valid. There is no combinational path from in_valid to any output.
- Reset (asynchronous, any time, including mid-stream):
  - All stage valid bits = 0, out_valid = 0, ovf = 0.
  - x0r, x0i, x1r, x1i = 0.
  - in_ready = 1 immediately after reset.
  - In-flight samples are discarded.
- clr_ovf takes effect at the next edge; ovf reads 0 the following cycle unless re-set.

## Configuration
- BFLY_SAT_EN defined: out-of-range results clamp to 2^(DW−1)−1 or −2^(DW−1).
- BFLY_SAT_EN undefined: results wrap to the low DW bits.
- ovf behaves identically in both builds.

## Test plan
All scenarios use DW=9, TW=9.
- x=(100,0), y=(64,0), w=(255,0), inv=0, scale=0 -> after 3 cycles out_valid=1, x0=(164,0), x1=(36,0), ovf=0.
- x=(200,0), y=(200,0), w=(255,0), scale=0 -> x0r=255 with BFLY_SAT_EN, −113 without; x1r=1; ovf=1. Repeat with scale=1 -> x0r=199, x1r=0, ovf unchanged. Then pulse clr_ovf -> ovf=0.
- x=(0,0), y=(0,100), w=(0,−256): inv=0 -> x0=(100,0), x1=(−100,0); inv=1 -> x0=(−100,0), x1=(100,0).
- Stream 8 back-to-back samples; hold out_ready=0 for 4 cycles mid-stream -> in_ready=0 during the stall, outputs stable, all 8 results emerge in order with none dropped or duplicated.
- Assert rst for 1 cycle with 3 samples in flight -> out_valid=0 and ovf=0 immediately; no stale sample appears afterwards; the next accepted sample emerges 3 cycles after acceptance.
